// File: rtl/mult_arbiter_if.sv
// Signal bundle between mult_arbiter, its two requesting channels and the 8x8 multiplier core.
// The master modport is the arbiter's view; slave is the environment's view.
interface mult_arbiter_if;
    logic        req0;
    logic        req1;
    logic [7:0]  a0;
    logic [7:0]  b0;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic        gnt0;
    logic        gnt1;
    logic        rsp_valid0;
    logic        rsp_valid1;
    logic [15:0] rsp_product;
    logic        rsp_err;
    logic        mult_start;
    logic [7:0]  mult_dataa;
    logic [7:0]  mult_datab;
    logic        mult_done;
    logic [15:0] mult_product;
    logic        busy;

    modport master (
        input  req0, req1, a0, b0, a1, b1, mult_done, mult_product,
        output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_product, rsp_err,
               mult_start, mult_dataa, mult_datab, busy
    );

    modport slave (
        output req0, req1, a0, b0, a1, b1, mult_done, mult_product,
        input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_product, rsp_err,
               mult_start, mult_dataa, mult_datab, busy
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one 8x8 multiplier core between two request channels.
// Optional WAIT-state abort after TIMEOUT_CYCLES is enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic           clk,
    input  logic           reset_a,
    mult_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t      state_q;
    logic        owner_q;
    logic        lastServed_q;
    logic        gnt0_q;
    logic        gnt1_q;
    logic        multStart_q;
    logic        rspValid0_q;
    logic        rspValid1_q;
    logic        busy_q;
    logic [7:0]  dataA_q;
    logic [7:0]  dataB_q;
    logic [15:0] rspProduct_q;
    logic        winner_d;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
        $error("mult_arbiter: TIMEOUT_CYCLES must lie in 2..255");
    end

`ifdef MULT_ARB_TIMEOUT_EN
    logic [7:0] waitCnt_q;
    logic       rspErr_q;
    assign bus.rsp_err = rspErr_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // Contention goes to the channel that was not served most recently.
    always_comb begin
        winner_d = 1'b0;
        if (bus.req0 && bus.req1) begin
            winner_d = ~lastServed_q;
        end else if (bus.req1) begin
            winner_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_a) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            lastServed_q <= 1'b1;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            multStart_q  <= 1'b0;
            rspValid0_q  <= 1'b0;
            rspValid1_q  <= 1'b0;
            busy_q       <= 1'b0;
            dataA_q      <= '0;
            dataB_q      <= '0;
            rspProduct_q <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            waitCnt_q    <= '0;
            rspErr_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state_q     <= START;
                        owner_q     <= winner_d;
                        gnt0_q      <= ~winner_d;
                        gnt1_q      <= winner_d;
                        multStart_q <= 1'b1;
                        busy_q      <= 1'b1;
                        dataA_q     <= winner_d ? bus.a1 : bus.a0;
                        dataB_q     <= winner_d ? bus.b1 : bus.b0;
                    end
                end
                START: begin
                    gnt0_q      <= 1'b0;
                    gnt1_q      <= 1'b0;
                    multStart_q <= 1'b0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    // A completion in the same cycle as the timeout takes priority.
                    if (bus.mult_done) begin
                        state_q      <= RESP;
                        rspProduct_q <= bus.mult_product;
                        rspValid0_q  <= ~owner_q;
                        rspValid1_q  <= owner_q;
`ifdef MULT_ARB_TIMEOUT_EN
                        rspErr_q     <= 1'b0;
                        waitCnt_q    <= '0;
                    end else if (waitCnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        state_q      <= RESP;
                        rspProduct_q <= '0;
                        rspValid0_q  <= ~owner_q;
                        rspValid1_q  <= owner_q;
                        rspErr_q     <= 1'b1;
                        waitCnt_q    <= '0;
                    end else begin
                        waitCnt_q    <= waitCnt_q + 8'd1;
`endif
                    end
                end
                RESP: begin
                    rspValid0_q  <= 1'b0;
                    rspValid1_q  <= 1'b0;
                    lastServed_q <= owner_q;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0        = gnt0_q;
    assign bus.gnt1        = gnt1_q;
    assign bus.mult_start  = multStart_q;
    assign bus.mult_dataa  = dataA_q;
    assign bus.mult_datab  = dataB_q;
    assign bus.rsp_valid0  = rspValid0_q;
    assign bus.rsp_valid1  = rspValid1_q;
    assign bus.rsp_product = rspProduct_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: a transaction-timeline model is compared every cycle,
// with literal spot checks on latency, products, arbitration order, timeout and reset abort.
module tb_mult_arbiter;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset_a;

    mult_arbiter_if busIf ();

    mult_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (busIf)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Multiplier core stand-in: answers coreDelay cycles after mult_start; 0 means never.
    int coreDelay   = 4;
    int corePending = 0;
    initial begin
        busIf.mult_done    = 1'b0;
        busIf.mult_product = '0;
        forever begin
            @(posedge clk);
            #1;
            busIf.mult_done = 1'b0;
            if (corePending > 0) begin
                corePending--;
                if (corePending == 0) begin
                    busIf.mult_done    = 1'b1;
                    busIf.mult_product = 16'(busIf.mult_dataa) * 16'(busIf.mult_datab);
                end
            end else if (busIf.mult_start === 1'b1 && coreDelay > 0) begin
                corePending = coreDelay;
            end
        end
    end

    // Timeline model: an operation is granted at cycle grantAt and answered at respAt.
    int          cyc       = 0;
    bit          modelLive = 0;
    bit          opOpen    = 0;
    bit          owner     = 0;
    bit          lastM     = 1;
    int          grantAt   = 0;
    int          respAt    = -1;
    logic [7:0]  expA      = '0;
    logic [7:0]  expB      = '0;
    logic [15:0] expProd   = '0;
    logic        expErr    = 1'b0;

    always @(posedge clk) begin
        cyc++;
        modelLive = 1;
        if (reset_a) begin
            opOpen  = 0;
            lastM   = 1;
            expA    = '0;
            expB    = '0;
            expProd = '0;
            expErr  = 1'b0;
        end else if (opOpen) begin
            if (respAt == cyc - 1) begin
                opOpen = 0;
                lastM  = owner;
            end else if (respAt < 0 && cyc - 1 > grantAt) begin
                if (busIf.mult_done) begin
                    respAt  = cyc;
                    expProd = busIf.mult_product;
                    expErr  = 1'b0;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (cyc - 1 - grantAt == TO) begin
                    respAt  = cyc;
                    expProd = '0;
                    expErr  = 1'b1;
                end
`endif
            end
        end else if (busIf.req0 || busIf.req1) begin
            owner   = (busIf.req0 && busIf.req1) ? !lastM : busIf.req1;
            grantAt = cyc;
            respAt  = -1;
            opOpen  = 1;
            expA    = owner ? busIf.a1 : busIf.a0;
            expB    = owner ? busIf.b1 : busIf.b0;
        end
    end

    int rspChLog[$];
    int rspProdLog[$];
    int gntLog[$];

    always @(negedge clk) begin : compare
        logic g;
        logic r;
        if (modelLive) begin
            g = opOpen && cyc == grantAt;
            r = opOpen && cyc == respAt;
            checkOutput("gnt0",        16'(busIf.gnt0),       16'(g && !owner));
            checkOutput("gnt1",        16'(busIf.gnt1),       16'(g && owner));
            checkOutput("mult_start",  16'(busIf.mult_start), 16'(g));
            checkOutput("busy",        16'(busIf.busy),       16'(opOpen));
            checkOutput("rsp_valid0",  16'(busIf.rsp_valid0), 16'(r && !owner));
            checkOutput("rsp_valid1",  16'(busIf.rsp_valid1), 16'(r && owner));
            checkOutput("rsp_product", busIf.rsp_product,     expProd);
            checkOutput("rsp_err",     16'(busIf.rsp_err),    16'(expErr));
            checkOutput("mult_dataa",  16'(busIf.mult_dataa), 16'(expA));
            checkOutput("mult_datab",  16'(busIf.mult_datab), 16'(expB));
        end
        if (busIf.gnt0 === 1'b1) gntLog.push_back(0);
        if (busIf.gnt1 === 1'b1) gntLog.push_back(1);
        if (busIf.rsp_valid0 === 1'b1) begin
            rspChLog.push_back(0);
            rspProdLog.push_back(int'(busIf.rsp_product));
        end
        if (busIf.rsp_valid1 === 1'b1) begin
            rspChLog.push_back(1);
            rspProdLog.push_back(int'(busIf.rsp_product));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        rspChLog.delete();
        rspProdLog.delete();
        gntLog.delete();
    endtask

    task automatic resetDut();
        reset_a    = 1'b1;
        busIf.req0 = 1'b0;
        busIf.req1 = 1'b0;
        tick();
        tick();
        reset_a = 1'b0;
    endtask

    // sel: 0 gnt0, 1 gnt1, 2 rsp_valid0, 3 rsp_valid1
    task automatic waitFor(input int sel, input int maxCycles, input string name, output int elapsed);
        bit seen;
        seen    = 0;
        elapsed = 0;
        while (!seen && elapsed < maxCycles) begin
            tick();
            elapsed++;
            case (sel)
                0:       seen = (busIf.gnt0 === 1'b1);
                1:       seen = (busIf.gnt1 === 1'b1);
                2:       seen = (busIf.rsp_valid0 === 1'b1);
                default: seen = (busIf.rsp_valid1 === 1'b1);
            endcase
        end
        checkOutput(name, 16'(seen), 16'd1);
    endtask

    // Raise the given requests, drop each once granted, and run until the arbiter is idle again.
    task automatic applyStimulus(input logic r0, input logic r1,
                                 input logic [7:0] pa0, input logic [7:0] pb0,
                                 input logic [7:0] pa1, input logic [7:0] pb1);
        int guard;
        bit drained;
        guard    = 0;
        drained  = 0;
        busIf.a0 = pa0;
        busIf.b0 = pb0;
        busIf.a1 = pa1;
        busIf.b1 = pb1;
        busIf.req0 = r0;
        busIf.req1 = r1;
        while (!drained && guard < 200) begin
            tick();
            guard++;
            if (busIf.gnt0 === 1'b1) busIf.req0 = 1'b0;
            if (busIf.gnt1 === 1'b1) busIf.req1 = 1'b0;
            drained = !busIf.req0 && !busIf.req1 && (busIf.busy === 1'b0);
        end
        checkOutput("stimulusDrained", 16'(drained), 16'd1);
    endtask

    initial begin : stimulus
        int n;
        reset_a    = 1'b1;
        busIf.req0 = 1'b0;
        busIf.req1 = 1'b0;
        busIf.a0   = '0;
        busIf.b0   = '0;
        busIf.a1   = '0;
        busIf.b1   = '0;
        resetDut();

        checkOutput("resetBusy",    16'(busIf.busy),       16'd0);
        checkOutput("resetGnt0",    16'(busIf.gnt0),       16'd0);
        checkOutput("resetProduct", busIf.rsp_product,     16'd0);
        checkOutput("resetDataA",   16'(busIf.mult_dataa), 16'd0);

        // Single channel-0 operation: grant one cycle after the request, core answers after 4.
        coreDelay = 4;
        clearLogs();
        busIf.a0   = 8'h0C;
        busIf.b0   = 8'h0A;
        busIf.req0 = 1'b1;
        tick();
        checkOutput("gnt0AtCycle1", 16'(busIf.gnt0),       16'd1);
        checkOutput("startAtCycle1", 16'(busIf.mult_start), 16'd1);
        busIf.req0 = 1'b0;
        waitFor(2, 20, "rsp033Seen", n);
        checkOutput("rsp033Latency", 16'(n),             16'd5);
        checkOutput("rsp033Product", busIf.rsp_product,  16'h0078);
        checkOutput("rsp033Err",     16'(busIf.rsp_err), 16'd0);
        repeat (2) tick();

        // Simultaneous requests straight after reset: channel 0 first.
        resetDut();
        coreDelay = 3;
        clearLogs();
        applyStimulus(1'b1, 1'b1, 8'd3, 8'd5, 8'd7, 8'd9);
        checkOutput("rsp034Count", 16'(rspChLog.size()), 16'd2);
        if (rspChLog.size() >= 2) begin
            checkOutput("rsp034FirstCh",   16'(rspChLog[0]),   16'd0);
            checkOutput("rsp034FirstProd", 16'(rspProdLog[0]), 16'd15);
            checkOutput("rsp034SecondCh",  16'(rspChLog[1]),   16'd1);
            checkOutput("rsp034SecondProd", 16'(rspProdLog[1]), 16'd63);
        end

        // Both requests held for four operations: grants alternate starting with channel 0.
        coreDelay = 2;
        clearLogs();
        busIf.a0   = 8'd2;
        busIf.b0   = 8'd3;
        busIf.a1   = 8'd4;
        busIf.b1   = 8'd5;
        busIf.req0 = 1'b1;
        busIf.req1 = 1'b1;
        n = 0;
        while (gntLog.size() < 4 && n < 100) begin
            tick();
            n++;
        end
        busIf.req0 = 1'b0;
        busIf.req1 = 1'b0;
        n = 0;
        while (busIf.busy !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("rr035Idle",  16'(busIf.busy),       16'd0);
        checkOutput("rr035Gnts",  16'(gntLog.size()),    16'd4);
        checkOutput("rr035Rsps",  16'(rspChLog.size()),  16'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gntLog.size())   checkOutput("rr035GntOrder", 16'(gntLog[i]),   16'(i % 2));
            if (i < rspChLog.size()) checkOutput("rr035RspCh",    16'(rspChLog[i]), 16'(i % 2));
            if (i < rspProdLog.size())
                checkOutput("rr035RspProd", 16'(rspProdLog[i]), (i % 2 == 0) ? 16'd6 : 16'd20);
        end

        // Largest operands on channel 1.
        coreDelay = 1;
        clearLogs();
        applyStimulus(1'b0, 1'b1, 8'd0, 8'd0, 8'hFF, 8'hFF);
        checkOutput("max036Count", 16'(rspChLog.size()), 16'd1);
        if (rspChLog.size() >= 1) begin
            checkOutput("max036Ch",   16'(rspChLog[0]),   16'd1);
            checkOutput("max036Prod", 16'(rspProdLog[0]), 16'hFE01);
        end

`ifdef MULT_ARB_TIMEOUT_EN
        // Completion on the last WAIT cycle beats the timeout.
        coreDelay = TO;
        clearLogs();
        busIf.a0   = 8'd11;
        busIf.b0   = 8'd13;
        busIf.req0 = 1'b1;
        tick();
        busIf.req0 = 1'b0;
        waitFor(2, 40, "race032Seen", n);
        checkOutput("race032Latency", 16'(n),             16'd17);
        checkOutput("race032Err",     16'(busIf.rsp_err), 16'd0);
        checkOutput("race032Prod",    busIf.rsp_product,  16'd143);
        repeat (2) tick();
`endif

        // Core never answers.
        coreDelay = 0;
        clearLogs();
        busIf.a0   = 8'd9;
        busIf.b0   = 8'd9;
        busIf.req0 = 1'b1;
        tick();
        checkOutput("to037Gnt0", 16'(busIf.gnt0), 16'd1);
        busIf.req0 = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
        waitFor(2, 40, "to037Seen", n);
        checkOutput("to037Latency", 16'(n),             16'd17);
        checkOutput("to037Err",     16'(busIf.rsp_err), 16'd1);
        checkOutput("to037Prod",    busIf.rsp_product,  16'd0);
        repeat (2) tick();
`else
        repeat (40) tick();
        checkOutput("to037BusyHeld", 16'(busIf.busy),       16'd1);
        checkOutput("to037NoRsp",    16'(rspChLog.size()),  16'd0);
`endif

        // Reset in the middle of WAIT with the core answering the cycle after.
        resetDut();
        coreDelay = 6;
        clearLogs();
        busIf.a0   = 8'd3;
        busIf.b0   = 8'd3;
        busIf.req0 = 1'b1;
        tick();
        checkOutput("abort038Gnt0", 16'(busIf.gnt0), 16'd1);
        busIf.req0 = 1'b0;
        repeat (5) tick();
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        checkOutput("abort038Busy",     16'(busIf.busy),      16'd0);
        checkOutput("abort038LateDone", 16'(busIf.mult_done), 16'd1);
        repeat (4) tick();
        checkOutput("abort038NoRsp",    16'(rspChLog.size()), 16'd0);
        checkOutput("abort038StillIdle", 16'(busIf.busy),     16'd0);
        coreDelay = 2;
        applyStimulus(1'b0, 1'b1, 8'd0, 8'd0, 8'd4, 8'd5);
        checkOutput("abort038NextCount", 16'(rspChLog.size()), 16'd1);
        if (rspChLog.size() >= 1) begin
            checkOutput("abort038NextCh",   16'(rspChLog[0]),   16'd1);
            checkOutput("abort038NextProd", 16'(rspProdLog[0]), 16'd20);
        end

        repeat (2) tick();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, max WAIT-state cycles before abort (range 2..255).
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 reset_a  in  1  synchronous, active-high reset.
REQ-004 req0 / req1  in  1 each  request from channel 0 / 1; level, held with operands until matching gnt.
REQ-005 a0, b0 / a1, b1  in  8 each  unsigned operands of channel 0 / 1.
REQ-006 gnt0 / gnt1  out  1 each  one-cycle grant pulse; operands sampled that cycle.
REQ-007 rsp_valid0 / rsp_valid1  out  1 each  one-cycle response pulse to owning channel.
REQ-008 rsp_product  out  16  product, valid only with rsp_valid0/1.
REQ-009 rsp_err  out  1  qualifies rsp_valid0/1; 1 = timed out, product forced 0.
REQ-010 mult_start  out  1  one-cycle start pulse to the 8x8 multiplier core.
REQ-011 mult_dataa / mult_datab  out  8 each  operands to core, held stable from START until RESP.
REQ-012 mult_done  in  1  completion pulse from core.
REQ-013 mult_product  in  16  core result, valid with mult_done.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 States: IDLE, START, WAIT, RESP; all outputs registered.
REQ-016 IDLE: no req -> stay; any req -> START next edge, winner chosen that cycle.
REQ-017 Arbitration round-robin: single req wins; both -> channel not served last; after reset ch0 favoured.
REQ-018 IDLE->START edge: latch winner's a/b into mult_dataa/mult_datab, record owner.
REQ-019 START (exactly 1 cycle): gnt of owner = 1, mult_start = 1; -> WAIT.
REQ-020 WAIT: mult_done = 1 -> capture mult_product into rsp_product, rsp_err = 0, -> RESP.
REQ-021 RESP (exactly 1 cycle): owner's rsp_valid = 1, last-served pointer = owner; -> IDLE.
REQ-022 Latency: req seen in IDLE at cycle 0 -> gnt at 1 -> rsp_valid one cycle after mult_done sampled.
REQ-023 mult_done outside WAIT ignored; mult_done in START cycle also ignored.
REQ-024 req sampled only in IDLE; requester drops req the cycle after gnt, else a new request.
REQ-025 Back-to-back: RESP->IDLE->START, minimum 4 cycles between successive mult_start pulses.
REQ-026 Outside RESP: rsp_valid0/1 = 0, rsp_product holds last value, rsp_err holds.
REQ-027 Products are 16-bit unsigned; 255*255 = 65025 (0xFE01) passed through unmodified.

Reset
REQ-028 reset_a high at an edge -> IDLE, all outputs 0, pointer favours ch0, timeout counter 0.
REQ-029 Reset overrides every state including mid-WAIT; no rsp_valid for aborted op; late mult_done ignored.

Configuration
REQ-030 Macro MULT_ARB_TIMEOUT_EN defined: WAIT counter increments per WAIT cycle; reaching TIMEOUT_CYCLES without mult_done -> RESP with rsp_err = 1, rsp_product = 0.
REQ-031 MULT_ARB_TIMEOUT_EN undefined: no counter, WAIT holds until mult_done; rsp_err tied 0.
REQ-032 mult_done and timeout in same cycle: mult_done wins, rsp_err = 0.

Verification
REQ-033 req0, a0=0x0C, b0=0x0A, core done after 4 cycles -> gnt0 at cycle 1, rsp_valid0 with rsp_product=0x0078, rsp_err=0.
REQ-034 req0+req1 together after reset (a0=3,b0=5; a1=7,b1=9) -> ch0 first (15), then ch1 (63); gnt1 never with gnt0.
REQ-035 Both req held continuously for 4 ops -> grants alternate 0,1,0,1; each rsp to owning channel.
REQ-036 a1=0xFF, b1=0xFF -> rsp_valid1, rsp_product=0xFE01.
REQ-037 TIMEOUT_EN defined, mult_done never asserted -> after 16 WAIT cycles rsp_valid0=1, rsp_err=1, product 0; without macro busy stays 1.
REQ-038 reset_a pulsed mid-WAIT, mult_done arrives next cycle -> no rsp_valid, busy=0, next req1 granted normally.
